uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// Words pushed on valid_i/ready_o are queued and serialised as
// start bit, DATA_W data bits (LSB first), optional parity, and STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [DATA_W-1:0]               data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic                            uart_tx_o,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH):0]     level_o
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
  localparam int unsigned STOP_CYC = STOP_BITS * BIT_CYC;
  localparam int unsigned CW       = $clog2(STOP_CYC + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned BW       = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;

  logic                full, empty, push, pop, load, bit_end;
  logic [DATA_W-1:0]   head;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign push    = valid_i & ~full;
  assign head    = mem[rd_ptr_q];
  assign bit_end = (cyc_q == CW'(BIT_CYC - 1));

  assign ready_o   = ~full;
  assign level_o   = level_q;
  assign uart_tx_o = tx_q;
  assign busy_o    = (state_q != IDLE) | ~empty;

  // FIFO storage: written on accepted pushes only, no reset needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Transmit FSM state and registered line output
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; the line value is computed one edge ahead so it leaves a register
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == BW'(DATA_W - 1)) begin
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          cyc_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (cyc_q == CW'(STOP_CYC - 1)) begin
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            cyc_d   = '0;
            tx_d    = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Shared by IDLE and end-of-STOP so back-to-back frames have no idle gap
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      cyc_d   = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (^head) ^ (PARITY == 2);
      tx_d    = 1'b0;
    end
  end

endmodule
